stream_capture_mc: RTL and testbench
====================================

Name: stream_capture_mc

Overview:
Multi-channel stream-to-memory capture engine for the snoop path. It takes NUM_PORTS Avalon-ST sniffer streams and buffers each in a small per-port FIFO. Each port writes its beats as tagged words into its own Avalon-MM memory window, honouring waitrequest. A CSR block controls arming, limit, wrap/one-shot mode and snoop reset, and reports per-port write pointer, drop count and state.

Parameters:
NUM_PORTS, 2, number of capture channels (1..8)
ST_WIDTH, 36, stream data width
MEM_WIDTH, 64, memory word width; must be > ST_WIDTH
ADDR_WIDTH, 20, memory word-address width per port
FIFO_DEPTH, 8, per-port buffer depth in beats (power of 2, >=2)

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  asynchronous active-low reset
csr_address  in  4  CSR word address
csr_write  in  1  CSR write strobe
csr_read  in  1  CSR read strobe
csr_writedata  in  32  CSR write data
csr_readdata  out  32  CSR read data, valid 1 cycle after csr_read
st_data  in  NUM_PORTS*ST_WIDTH  stream data, port p at slice p
st_valid  in  NUM_PORTS  stream valid per port (no backpressure)
mem_address  out  NUM_PORTS*ADDR_WIDTH  word address per port
mem_write  out  NUM_PORTS  write request per port
mem_writedata  out  NUM_PORTS*MEM_WIDTH  write data per port
mem_waitrequest  in  NUM_PORTS  slave stall per port
snoop_reset  out  1  reset to upstream sniffers, from CTRL bit

Behaviour:
- Reset values: mem_write=0, mem_address=0, mem_writedata=0, csr_readdata=0, snoop_reset=0, all ports IDLE, CSRs 0 except LIMIT=all ones.
- CSR map: 0 CTRL [0]arm [1]wrap [2]snoop_reset [3]clear (self-clearing); 1 STATUS [2p+1:2p]=port state, [16+p]=overflow sticky; 2 LIMIT (words, ADDR_WIDTH bits); 4+p PTR[p]; 8+p DROPS[p] (16-bit saturating); unmapped addresses read 0 and ignore writes.
- Per-port FSM: IDLE -> RUN when arm is written 0->1. Entering RUN clears the pointer, FIFO, drops, overflow and sequence counter.
- RUN -> DRAIN on arm written to 0. RUN -> DRAIN on an accepted write at address LIMIT-1 with wrap=0.
- DRAIN -> IDLE once the FIFO is empty, if arm=0. DRAIN -> DONE once the FIFO is empty, if the limit was hit. DONE -> RUN on arm written 0->1. clear forces every port to IDLE in the next cycle.
- Capture: in RUN only, each st_valid beat is pushed with a tag. The tag is the per-port sequence count, truncated to MEM_WIDTH-ST_WIDTH bits, which increments per pushed beat. Word = {tag, data}. Capture latency is valid -> FIFO in 1 cycle.
- FIFO full: the beat is dropped, DROPS increments (saturating at 0xFFFF) and overflow sets. A push and pop in the same cycle while full is accepted, not dropped.
- Writer: mem_write=1 whenever the FIFO head is valid in RUN or DRAIN. mem_address and mem_writedata hold stable while waitrequest=1. A write is accepted when mem_write=1 and waitrequest=0; on acceptance the FIFO pops and the address increments.
- Address: after LIMIT-1 the address goes to 0 if wrap=1; if wrap=0, capture stops. LIMIT=0 is treated as 2^ADDR_WIDTH. PTR reads the next address.
- Ports are fully independent; no arbitration between them.
- Async reset mid-burst: mem_write drops immediately; in-flight data is discarded.

Decomposition:
- Package stream_capture_pkg: CSR address localparams, CTRL bit indices, port state enum {IDLE, RUN, DRAIN, DONE} (2 bits).
- Sub-module stream_capture_port: FIFO, FSM, address/sequence/drop counters for one channel, instantiated NUM_PORTS times in a generate loop.
- The top level holds the CSR decode, readback mux and the arm edge detect.

Test Plan:
- Arm with wrap=0, LIMIT=4, 6 consecutive valid beats on port 0, waitrequest=0 -> writes to addresses 0,1,2,3 with tags 0..3, then DONE (STATUS[1:0]=3), PTR0=0 after the limit, mem_write low.
- Port 1 waitrequest held high for 20 cycles with 10 valid beats, FIFO_DEPTH=8 -> address and data stay stable, DROPS1=2, overflow bit 17 set, 8 words land after release.
- wrap=1, LIMIT=3, 7 beats -> address sequence 0,1,2,0,1,2,0; tags 0..6; state remains RUN.
- Disarm with 3 beats queued behind waitrequest -> DRAIN, 3 writes complete, then IDLE; beats arriving in DRAIN are not captured.
- Write CTRL=0x4 -> snoop_reset=1 the next cycle; write 0x8 while running -> all ports IDLE; reset_n low mid-write -> mem_write=0 asynchronously and CSRs return to reset values.
- Read csr_address 15 -> 0; read LIMIT after reset -> 0x000FFFFF.

Source files
------------

// File: rtl/stream_capture_pkg.sv
// Shared definitions for the stream capture engine:
// CSR addresses, CTRL bit positions and the per-port state encoding.
package stream_capture_pkg;

  localparam logic [3:0] CSR_CTRL   = 4'd0;
  localparam logic [3:0] CSR_STATUS = 4'd1;
  localparam logic [3:0] CSR_LIMIT  = 4'd2;
  localparam logic [3:0] CSR_PTR    = 4'd4;
  localparam logic [3:0] CSR_DROPS  = 4'd8;

  localparam int CTRL_ARM   = 0;
  localparam int CTRL_WRAP  = 1;
  localparam int CTRL_SNOOP = 2;
  localparam int CTRL_CLEAR = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } port_state_e;

endpackage

// File: rtl/stream_capture_port.sv
// One capture channel: beat FIFO, run/drain FSM, address, tag and drop counters.
// Ports: arm/clear pulses and wrap/limit config in; stream in; MM writer and status out.
module stream_capture_port
  import stream_capture_pkg::*;
#(
  parameter int ST_WIDTH   = 36,
  parameter int MEM_WIDTH  = 64,
  parameter int ADDR_WIDTH = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm_rise_i,
  input  logic                  arm_fall_i,
  input  logic                  clear_i,
  input  logic                  wrap_i,
  input  logic [ADDR_WIDTH-1:0] limit_i,
  input  logic [ST_WIDTH-1:0]   st_data_i,
  input  logic                  st_valid_i,
  input  logic                  mem_waitrequest_i,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic                  mem_write_o,
  output logic [MEM_WIDTH-1:0]  mem_writedata_o,
  output port_state_e           state_o,
  output logic [ADDR_WIDTH-1:0] ptr_o,
  output logic [15:0]           drops_o,
  output logic                  ovf_o
);

  localparam int TW = MEM_WIDTH - ST_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  port_state_e state_q, state_d;

  logic [MEM_WIDTH-1:0]  fifo_q [FIFO_DEPTH];
  logic [PW-1:0]         wp_q, rp_q;
  logic [PW:0]           cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [TW-1:0]         seq_q;
  logic [15:0]           drops_q;
  logic                  ovf_q, hit_q;

  logic empty, full, last, accept, hit;
  logic push, pop, drop, enter_run;

  assign empty  = cnt_q == '0;
  assign full   = cnt_q == FULL_CNT;
  // LIMIT=0 wraps to all ones here, i.e. a 2^ADDR_WIDTH window
  assign last   = addr_q == (limit_i - A_ONE);
  assign accept = mem_write_o && !mem_waitrequest_i;
  assign hit    = accept && last && !wrap_i;
  assign pop    = accept;
  // a pop in the same cycle frees the slot, so full+pop still accepts
  assign push   = st_valid_i && state_q == RUN
                && (!full || pop);
  assign drop   = st_valid_i && state_q == RUN && !push;
  assign enter_run = state_q != RUN && state_d == RUN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (arm_rise_i) state_d = RUN;
      RUN:        if (arm_fall_i || hit) state_d = DRAIN;
      DRAIN:      if (empty) state_d = hit_q ? DONE : IDLE;
      default:    state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_comb begin
    mem_write_o = 1'b0;
    unique case (state_q)
      RUN, DRAIN: mem_write_o = !empty;
      default:    mem_write_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= {seq_q, st_data_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      seq_q   <= '0;
      drops_q <= '0;
      ovf_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else if (enter_run || clear_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      hit_q <= 1'b0;
      if (enter_run) begin
        addr_q  <= '0;
        seq_q   <= '0;
        drops_q <= '0;
        ovf_q   <= 1'b0;
      end
    end else begin
      // limit reached without wrap: discard the backlog
      if (hit) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
        hit_q <= 1'b1;
      end else begin
        if (push) wp_q <= wp_q + 1'b1;
        if (pop)  rp_q <= rp_q + 1'b1;
        unique case ({push, pop})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
      if (accept) addr_q <= last ? '0 : addr_q + A_ONE;
      if (push)   seq_q  <= seq_q + 1'b1;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drops_q != 16'hFFFF) drops_q <= drops_q + 16'd1;
      end
    end
  end

  assign mem_address_o   = addr_q;
  assign mem_writedata_o = mem_write_o ? fifo_q[rp_q] : '0;
  assign state_o         = state_q;
  assign ptr_o           = addr_q;
  assign drops_o         = drops_q;
  assign ovf_o           = ovf_q;

endmodule

// File: rtl/stream_capture_mc.sv
// Multi-channel stream-to-memory capture: CSR decode, readback and arm edges.
// Ports: CSR slave, NUM_PORTS sniffer streams, NUM_PORTS MM write masters, snoop_reset.
module stream_capture_mc
  import stream_capture_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ST_WIDTH   = 36,
  parameter int MEM_WIDTH  = 64,
  parameter int ADDR_WIDTH = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [3:0]                      csr_address,
  input  logic                            csr_write,
  input  logic                            csr_read,
  input  logic [31:0]                     csr_writedata,
  output logic [31:0]                     csr_readdata,
  input  logic [NUM_PORTS*ST_WIDTH-1:0]   st_data,
  input  logic [NUM_PORTS-1:0]            st_valid,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0] mem_address,
  output logic [NUM_PORTS-1:0]            mem_write,
  output logic [NUM_PORTS*MEM_WIDTH-1:0]  mem_writedata,
  input  logic [NUM_PORTS-1:0]            mem_waitrequest,
  output logic                            snoop_reset
);

  logic                  arm_q, wrap_q, snoop_q;
  logic [ADDR_WIDTH-1:0] limit_q;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ctrl_wr, arm_rise, arm_fall, clear;

  port_state_e           st    [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] ptr   [NUM_PORTS];
  logic [15:0]           drops [NUM_PORTS];
  logic [NUM_PORTS-1:0]  ovf;

  assign ctrl_wr  = csr_write && csr_address == CSR_CTRL;
  assign arm_rise = ctrl_wr && csr_writedata[CTRL_ARM] && !arm_q;
  assign arm_fall = ctrl_wr && !csr_writedata[CTRL_ARM] && arm_q;
  assign clear    = ctrl_wr && csr_writedata[CTRL_CLEAR];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_q   <= 1'b0;
      wrap_q  <= 1'b0;
      snoop_q <= 1'b0;
      limit_q <= '1;
      rdata_q <= '0;
    end else begin
      if (ctrl_wr) begin
        arm_q   <= csr_writedata[CTRL_ARM];
        wrap_q  <= csr_writedata[CTRL_WRAP];
        snoop_q <= csr_writedata[CTRL_SNOOP];
      end
      if (csr_write && csr_address == CSR_LIMIT)
        limit_q <= csr_writedata[ADDR_WIDTH-1:0];
      if (csr_read) rdata_q <= rdata_d;
    end
  end

  always_comb begin
    rdata_d = '0;
    unique case (1'b1)
      csr_address == CSR_CTRL: begin
        rdata_d[CTRL_ARM]   = arm_q;
        rdata_d[CTRL_WRAP]  = wrap_q;
        rdata_d[CTRL_SNOOP] = snoop_q;
      end
      csr_address == CSR_STATUS: begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          rdata_d[2*p +: 2] = st[p];
          rdata_d[16+p]     = ovf[p];
        end
      end
      csr_address == CSR_LIMIT:
        rdata_d[ADDR_WIDTH-1:0] = limit_q;
      default: begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (p < 4 && csr_address == CSR_PTR + 4'(p))
            rdata_d[ADDR_WIDTH-1:0] = ptr[p];
          if (csr_address == CSR_DROPS + 4'(p))
            rdata_d[15:0] = drops[p];
        end
      end
    endcase
  end

  assign csr_readdata = rdata_q;
  assign snoop_reset  = snoop_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    stream_capture_port #(
      .ST_WIDTH   (ST_WIDTH),
      .MEM_WIDTH  (MEM_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_port (
      .clk               (clk),
      .rst_n             (reset_n),
      .arm_rise_i        (arm_rise),
      .arm_fall_i        (arm_fall),
      .clear_i           (clear),
      .wrap_i            (wrap_q),
      .limit_i           (limit_q),
      .st_data_i         (st_data[g*ST_WIDTH +: ST_WIDTH]),
      .st_valid_i        (st_valid[g]),
      .mem_waitrequest_i (mem_waitrequest[g]),
      .mem_address_o     (mem_address[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .mem_write_o       (mem_write[g]),
      .mem_writedata_o   (mem_writedata[g*MEM_WIDTH +: MEM_WIDTH]),
      .state_o           (st[g]),
      .ptr_o             (ptr[g]),
      .drops_o           (drops[g]),
      .ovf_o             (ovf[g])
    );
  end

endmodule

// File: tb/tb_stream_capture_mc.sv
// Scoreboard bench for stream_capture_mc: expected memory writes are
// queued when beats are issued and checked by an independent monitor.
module tb_stream_capture_mc;

  localparam int NP = 2;
  localparam int SW = 36;
  localparam int MW = 64;
  localparam int AW = 20;
  localparam int FD = 8;
  localparam int TW = MW - SW;
  localparam int BIG = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [3:0]    csr_address = '0;
  logic          csr_write = 1'b0;
  logic          csr_read = 1'b0;
  logic [31:0]   csr_writedata = '0;
  logic [31:0]   csr_readdata;
  logic [NP*SW-1:0] st_data = '0;
  logic [NP-1:0] st_valid = '0;
  logic [NP*AW-1:0] mem_address;
  logic [NP-1:0] mem_write;
  logic [NP*MW-1:0] mem_writedata;
  logic [NP-1:0] mem_waitrequest = '0;
  logic          snoop_reset;

  always #5 clk = ~clk;

  stream_capture_mc #(
    .NUM_PORTS(NP), .ST_WIDTH(SW), .MEM_WIDTH(MW),
    .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_address(csr_address), .csr_write(csr_write),
    .csr_read(csr_read), .csr_writedata(csr_writedata),
    .csr_readdata(csr_readdata),
    .st_data(st_data), .st_valid(st_valid),
    .mem_address(mem_address), .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_waitrequest(mem_waitrequest),
    .snoop_reset(snoop_reset)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [MW-1:0] d;
  } exp_t;

  exp_t sbq [NP][$];
  int errors = 0;
  int checks = 0;
  int seqn [NP];

  logic [NP-1:0] stall_q = '0;
  logic [AW-1:0] hold_a [NP];
  logic [MW-1:0] hold_d [NP];
  logic [AW-1:0] mon_a;
  logic [MW-1:0] mon_d;
  exp_t          mon_e;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: stall stability and accepted writes against the scoreboard
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      mon_a = mem_address[p*AW +: AW];
      mon_d = mem_writedata[p*MW +: MW];
      if (stall_q[p] && mem_write[p]) begin
        chk($sformatf("hold_addr%0d", p), 64'(mon_a), 64'(hold_a[p]));
        chk($sformatf("hold_data%0d", p), mon_d, hold_d[p]);
      end
      if (mem_write[p] && !mem_waitrequest[p]) begin
        if (sbq[p].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write%0d: got addr %0h data %0h, expected none",
                   p, mon_a, mon_d);
        end else begin
          mon_e = sbq[p].pop_front();
          chk($sformatf("wr_addr%0d", p), 64'(mon_a), 64'(mon_e.a));
          chk($sformatf("wr_data%0d", p), mon_d, mon_e.d);
        end
      end
      stall_q[p] = mem_write[p] && mem_waitrequest[p];
      hold_a[p]  = mon_a;
      hold_d[p]  = mon_d;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    tick();
    csr_write     = 1'b0;
  endtask

  task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
    csr_address = a;
    csr_read    = 1'b1;
    tick();
    csr_read    = 1'b0;
    d           = csr_readdata;
  endtask

  // present one beat; if it is expected to land, the k-th captured
  // beat goes to address k mod window with tag k
  task automatic drive(input int p, input bit cap, input int win);
    logic [SW-1:0] d;
    exp_t e;
    d = SW'({$urandom(), $urandom()});
    st_data[p*SW +: SW] = d;
    st_valid[p] = 1'b1;
    if (cap) begin
      e.a = AW'(seqn[p] % win);
      e.d = {TW'(seqn[p]), d};
      sbq[p].push_back(e);
      seqn[p]++;
    end
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((sbq[0].size() + sbq[1].size()) != 0 && n < maxc) begin
      tick();
      n++;
    end
    chk("drain_left", 64'(sbq[0].size() + sbq[1].size()), 64'd0);
    repeat (2) tick();
  endtask

  logic [31:0] r;

  initial begin
    seqn = '{0, 0};
    repeat (3) tick();
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_mem_address", 64'(mem_address), 64'd0);
    chk("rst_writedata", mem_writedata[63:0], 64'd0);
    chk("rst_snoop", 64'(snoop_reset), 64'd0);
    chk("rst_readdata", 64'(csr_readdata), 64'd0);
    reset_n = 1'b1;
    tick();
    csr_rd(4'd2, r);  chk("rst_limit", 64'(r), 64'h000F_FFFF);
    csr_rd(4'd1, r);  chk("rst_status", 64'(r), 64'd0);
    csr_rd(4'd0, r);  chk("rst_ctrl", 64'(r), 64'd0);
    csr_rd(4'd15, r); chk("unmapped15", 64'(r), 64'd0);
    csr_wr(4'd3, 32'hFFFF_FFFF);
    csr_rd(4'd3, r);  chk("unmapped3", 64'(r), 64'd0);

    // one-shot, LIMIT=4, six back-to-back beats
    csr_wr(4'd2, 32'd4);
    csr_wr(4'd0, 32'h1);
    seqn = '{0, 0};
    for (int i = 0; i < 6; i++) begin
      drive(0, i < 4, 4);
      tick();
    end
    st_valid = '0;
    drain(20);
    csr_rd(4'd1, r); chk("s1_state0", 64'(r[1:0]), 64'd3);
    csr_rd(4'd4, r); chk("s1_ptr0", 64'(r), 64'd0);
    chk("s1_mem_write", 64'(mem_write[0]), 64'd0);

    // port 1 stalled 20 cycles with 10 beats into an 8-deep buffer
    csr_wr(4'd0, 32'h0);
    csr_wr(4'd2, 32'h0);
    csr_wr(4'd0, 32'h1);
    seqn = '{0, 0};
    mem_waitrequest[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i < 10) drive(1, i < 8, BIG);
      else st_valid[1] = 1'b0;
      tick();
    end
    csr_rd(4'd1, r); chk("s2_ovf1", 64'(r[17]), 64'd1);
    chk("s2_ovf0", 64'(r[16]), 64'd0);
    csr_rd(4'd9, r); chk("s2_drops1", 64'(r), 64'd2);
    mem_waitrequest[1] = 1'b0;
    drain(30);
    csr_rd(4'd5, r); chk("s2_ptr1", 64'(r), 64'd8);
    csr_rd(4'd8, r); chk("s2_drops0", 64'(r), 64'd0);

    // wrap, LIMIT=3: seven beats, then random traffic
    csr_wr(4'd0, 32'h0);
    repeat (2) tick();
    csr_wr(4'd2, 32'd3);
    csr_wr(4'd0, 32'h3);
    seqn = '{0, 0};
    for (int i = 0; i < 7; i++) begin
      drive(0, 1'b1, 3);
      tick();
    end
    st_valid = '0;
    drain(20);
    csr_rd(4'd1, r); chk("s3_run0", 64'(r[1:0]), 64'd1);
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < NP; p++) begin
        mem_waitrequest[p] = ($urandom_range(0, 3) == 0);
        if (sbq[p].size() < FD - 2 && $urandom_range(0, 1) == 1)
          drive(p, 1'b1, 3);
        else
          st_valid[p] = 1'b0;
      end
      tick();
    end
    st_valid = '0;
    mem_waitrequest = '0;
    drain(40);
    csr_rd(4'd1, r); chk("s3_status", 64'(r), 64'h5);
    csr_rd(4'd8, r); chk("s3_drops0", 64'(r), 64'd0);
    csr_rd(4'd9, r); chk("s3_drops1", 64'(r), 64'd0);

    // disarm with three beats queued behind waitrequest
    csr_wr(4'd0, 32'h0);
    repeat (2) tick();
    csr_wr(4'd2, 32'h0);
    csr_wr(4'd0, 32'h1);
    seqn = '{0, 0};
    mem_waitrequest[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, BIG);
      tick();
    end
    st_valid = '0;
    csr_wr(4'd0, 32'h0);
    drive(0, 1'b0, 1);
    csr_rd(4'd1, r); chk("s4_drain0", 64'(r[1:0]), 64'd2);
    st_valid = '0;
    mem_waitrequest[0] = 1'b0;
    drain(20);
    csr_rd(4'd1, r); chk("s4_idle0", 64'(r[1:0]), 64'd0);
    csr_rd(4'd4, r); chk("s4_ptr0", 64'(r), 64'd3);

    // snoop reset, clear, async reset mid-write
    csr_wr(4'd0, 32'h4);
    chk("s5_snoop", 64'(snoop_reset), 64'd1);
    csr_wr(4'd0, 32'h5);
    csr_rd(4'd1, r); chk("s5_run", 64'(r), 64'h5);
    csr_wr(4'd0, 32'h8);
    csr_rd(4'd1, r); chk("s5_clear", 64'(r), 64'd0);
    chk("s5_snoop_off", 64'(snoop_reset), 64'd0);
    csr_wr(4'd0, 32'h1);
    seqn = '{0, 0};
    mem_waitrequest[0] = 1'b1;
    drive(0, 1'b1, BIG);
    tick();
    st_valid = '0;
    tick();
    chk("s5_write_up", 64'(mem_write[0]), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("s5_async_drop", 64'(mem_write), 64'd0);
    sbq[0].delete();
    mem_waitrequest = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    csr_rd(4'd2, r); chk("s5_limit", 64'(r), 64'h000F_FFFF);
    csr_rd(4'd0, r); chk("s5_ctrl", 64'(r), 64'd0);
    csr_rd(4'd1, r); chk("s5_status", 64'(r), 64'd0);
    chk("s5_addr", 64'(mem_address), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
